// File: rtl/cart_mem_arbiter.sv
// Two-requester (CPU/mapper A, loader/DMA B) arbiter onto one cartridge memory port.
// Define CART_MEM_ARB_TIMEOUT_EN to build the SERVE-state timeout and sticky timeout_err.
module cart_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        a_req,
    input  logic [22:0] a_addr,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [22:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        timeout_err
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

    state_t        state, state_nxt;
    logic          mem_req_nxt, mem_we_nxt;
    logic [22:0]   mem_addr_nxt;
    logic [7:0]    mem_wdata_nxt;
    logic          a_ack_nxt, b_ack_nxt;
    logic [7:0]    a_rdata_nxt, b_rdata_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          fin;
    logic [7:0]    fin_data;

`ifdef CART_MEM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          err_nxt;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            starve_cnt <= '0;
        end else begin
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            a_ack      <= a_ack_nxt;
            b_ack      <= b_ack_nxt;
            a_rdata    <= a_rdata_nxt;
            b_rdata    <= b_rdata_nxt;
            starve_cnt <= starve_nxt;
        end
    end

`ifdef CART_MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt     <= tmo_nxt;
            timeout_err <= err_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        a_ack_nxt     = 1'b0;
        b_ack_nxt     = 1'b0;
        a_rdata_nxt   = a_rdata;
        b_rdata_nxt   = b_rdata;
        starve_nxt    = starve_cnt;
        fin           = 1'b0;
        fin_data      = mem_rdata;
`ifdef CART_MEM_ARB_TIMEOUT_EN
        tmo_nxt       = '0;
        err_nxt       = timeout_err;
`endif
        case (state)
            IDLE: begin
                if (!b_req) starve_nxt = '0;
                // The cycle carrying an ack is a dead cycle: the acked requester
                // has not yet dropped its level request, so nothing is granted.
                if (!a_ack && !b_ack) begin
                    if (b_req && (!a_req || starve_cnt >= STARVE_MAX)) begin
                        state_nxt     = SERVE_B;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = b_we;
                        mem_addr_nxt  = b_addr;
                        mem_wdata_nxt = b_wdata;
                        starve_nxt    = '0;
                    end else if (a_req) begin
                        state_nxt    = SERVE_A;
                        mem_req_nxt  = 1'b1;
                        mem_we_nxt   = 1'b0;
                        mem_addr_nxt = a_addr;
                        if (b_req && starve_cnt < STARVE_MAX) starve_nxt = starve_cnt + 1'b1;
                    end
                end
            end
            SERVE_A, SERVE_B: begin
                if (mem_ack) begin
                    fin = 1'b1;
`ifdef CART_MEM_ARB_TIMEOUT_EN
                end else if (tmo_cnt == TMO_LAST) begin
                    fin      = 1'b1;
                    fin_data = 8'hFF;
                    err_nxt  = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (fin) begin
            state_nxt   = IDLE;
            mem_req_nxt = 1'b0;
            if (state == SERVE_A) begin
                a_ack_nxt   = 1'b1;
                a_rdata_nxt = fin_data;
            end else begin
                b_ack_nxt = 1'b1;
                if (!mem_we) b_rdata_nxt = fin_data;
            end
        end
    end
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter: grants and acks are checked by a negedge monitor
// against queues filled by the directed stimulus; timeout case runs when CART_MEM_ARB_TIMEOUT_EN is set.
module tb_cart_mem_arbiter;
`ifdef CART_MEM_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        a_req;
    logic [22:0] a_addr;
    logic        a_ack;
    logic [7:0]  a_rdata;
    logic        b_req;
    logic        b_we;
    logic [22:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_ack;
    logic [7:0]  b_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic        timeout_err;

    always #5 clk_sys = ~clk_sys;

    cart_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct { logic [22:0] addr; logic we; logic [7:0] wdata; } grant_t;
    typedef struct { logic port; logic [7:0] rdata; logic lat_chk; } ack_t;
    grant_t grant_q[$];
    ack_t   ack_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got no/unexpected event, expected a matching one", name);
    endtask

    // Memory model: acks mem_req after mem_lat cycles unless held off; force_ack injects a stray ack.
    logic       mem_hold = 1'b0;
    logic       force_ack = 1'b0;
    int         mem_lat = 1;
    int         lat_cnt = 0;
    logic [7:0] rd_val = 8'h00;
    always @(posedge clk_sys) begin
        #2;
        if (mem_ack) begin
            mem_ack = 1'b0;
            lat_cnt = 0;
        end else if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_val;
        end else if (mem_req && !mem_hold) begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_val;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // Monitor
    logic req_prev = 1'b0;
    logic ack_prev = 1'b0;
    always @(negedge clk_sys) begin
        grant_t g;
        ack_t   e;
        if (mem_req && !req_prev) begin
            if (grant_q.size() == 0) fail_now("unexpected_grant");
            else begin
                g = grant_q.pop_front();
                check("grant_addr", 32'(mem_addr), 32'(g.addr));
                check("grant_we", 32'(mem_we), 32'(g.we));
                if (g.we) check("grant_wdata", 32'(mem_wdata), 32'(g.wdata));
                check("grant_busy", 32'(busy), 32'd1);
            end
        end
        if (a_ack || b_ack) begin
            if (ack_q.size() == 0) fail_now("unexpected_ack");
            else begin
                e = ack_q.pop_front();
                check("ack_port", 32'(b_ack), 32'(e.port));
                check("ack_rdata", e.port ? 32'(b_rdata) : 32'(a_rdata), 32'(e.rdata));
                if (e.lat_chk) check("ack_after_mem_ack", 32'(ack_prev), 32'd1);
                check("ack_mem_req_low", 32'(mem_req), 32'd0);
            end
        end
        req_prev = mem_req;
        ack_prev = mem_ack;
    end

    task automatic wait_ack(input logic port, input int budget);
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!(port ? b_ack : a_ack) && n < budget);
        if (!(port ? b_ack : a_ack)) fail_now(port ? "b_ack_wait" : "a_ack_wait");
    endtask

    task automatic a_read(input logic [22:0] addr, input logic [7:0] rd, input int lat);
        grant_q.push_back('{addr, 1'b0, 8'h00});
        ack_q.push_back('{1'b0, rd, 1'b1});
        rd_val  = rd;
        mem_lat = lat;
        a_addr  = addr;
        a_req   = 1'b1;
        @(negedge clk_sys);
        a_addr = ~addr;
        wait_ack(1'b0, 40);
        a_req = 1'b0;
        check("a_addr_stable", 32'(mem_addr), 32'(addr));
        @(negedge clk_sys);
    endtask

    logic [7:0] exp_b_rdata = 8'h00;
    task automatic b_access(input logic we, input logic [22:0] addr, input logic [7:0] wd,
                            input logic [7:0] rd, input int lat);
        if (!we) exp_b_rdata = rd;
        grant_q.push_back('{addr, we, wd});
        ack_q.push_back('{1'b1, exp_b_rdata, 1'b1});
        rd_val  = rd;
        mem_lat = lat;
        b_we    = we;
        b_addr  = addr;
        b_wdata = wd;
        b_req   = 1'b1;
        @(negedge clk_sys);
        b_addr  = ~addr;
        b_wdata = ~wd;
        wait_ack(1'b1, 40);
        b_req = 1'b0;
        check("b_addr_stable", 32'(mem_addr), 32'(addr));
        if (we) check("b_wdata_stable", 32'(mem_wdata), 32'(wd));
        @(negedge clk_sys);
    endtask

    int n, cnt, acks;

    initial begin
        reset = 1'b1; a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = 1'b0;
        b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_a_ack", 32'(a_ack), 32'd0);
        check("rst_b_ack", 32'(b_ack), 32'd0);
        check("rst_a_rdata", 32'(a_rdata), 32'd0);
        check("rst_b_rdata", 32'(b_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // Stray mem_ack while idle
        rd_val = 8'hEE; force_ack = 1'b1;
        @(negedge clk_sys);
        force_ack = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("idle_ack_busy", 32'(busy), 32'd0);
        check("idle_ack_a_rdata", 32'(a_rdata), 32'd0);
        check("idle_ack_b_rdata", 32'(b_rdata), 32'd0);

        // A read, 3-cycle memory
        a_read(23'h004001, 8'h3C, 3);
        repeat (2) @(negedge clk_sys);
        check("a_rdata_held", 32'(a_rdata), 32'h3C);

        // Both requesting continuously: A,A,A,A,B,A,A,A,A,B
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                grant_q.push_back('{23'h000200, 1'b0, 8'h00});
                ack_q.push_back('{1'b1, 8'h5A, 1'b1});
            end else begin
                grant_q.push_back('{23'h000100, 1'b0, 8'h00});
                ack_q.push_back('{1'b0, 8'h5A, 1'b1});
            end
        end
        rd_val = 8'h5A; mem_lat = 1;
        a_addr = 23'h000100; b_addr = 23'h000200; b_we = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        acks = 0; n = 0;
        while (acks < 10 && n < 200) begin
            @(negedge clk_sys);
            n++;
            if (a_ack || b_ack) acks++;
            if (acks >= 9) a_req = 1'b0;
            if (acks >= 10) b_req = 1'b0;
        end
        a_req = 1'b0; b_req = 1'b0;
        if (acks < 10) fail_now("starve_seq_acks");
        exp_b_rdata = 8'h5A;
        repeat (2) @(negedge clk_sys);

        // B read then B write to the top address; write keeps b_rdata
        b_access(1'b0, 23'h000123, 8'h00, 8'h77, 2);
        b_access(1'b1, 23'h7FFFFF, 8'hA5, 8'h00, 1);
        check("b_write_keeps_rdata", 32'(b_rdata), 32'h77);

        // Reset during SERVE_B, then a late mem_ack
        grant_q.push_back('{23'h000321, 1'b0, 8'h00});
        mem_hold = 1'b1; rd_val = 8'h99;
        b_we = 1'b0; b_addr = 23'h000321; b_req = 1'b1;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!mem_req && n < 10);
        if (!mem_req) fail_now("serve_b_entry");
        #2 reset = 1'b1; b_req = 1'b0;
        #1;
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_b_ack", 32'(b_ack), 32'd0);
        check("abort_b_rdata", 32'(b_rdata), 32'd0);
        check("abort_a_rdata", 32'(a_rdata), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        mem_hold = 1'b0; force_ack = 1'b1;
        @(negedge clk_sys);
        force_ack = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("late_ack_busy", 32'(busy), 32'd0);
        check("late_ack_mem_req", 32'(mem_req), 32'd0);
        check("late_ack_b_rdata", 32'(b_rdata), 32'd0);

`ifdef CART_MEM_ARB_TIMEOUT_EN
        // Withheld ack on an A read
        grant_q.push_back('{23'h000055, 1'b0, 8'h00});
        ack_q.push_back('{1'b0, 8'hFF, 1'b0});
        mem_hold = 1'b1; a_addr = 23'h000055; a_req = 1'b1;
        cnt = 0; n = 0;
        do begin
            @(negedge clk_sys);
            n++;
            if (mem_req) cnt++;
        end while (!a_ack && n < 40);
        a_req = 1'b0;
        if (!a_ack) fail_now("tmo_a_ack_wait");
        check("tmo_req_cycles", 32'(cnt), 32'd8);
        check("tmo_err_set", 32'(timeout_err), 32'd1);
        repeat (5) @(negedge clk_sys);
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);
        mem_hold = 1'b0;
        #2 reset = 1'b1;
        #1 check("tmo_err_cleared", 32'(timeout_err), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk_sys);
`else
        check("no_tmo_err", 32'(timeout_err), 32'd0);
`endif

        n = 0;
        while ((grant_q.size() != 0 || ack_q.size() != 0) && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        if (grant_q.size() != 0 || ack_q.size() != 0) fail_now("scoreboard_drain");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
